aoi21_pipe_array: RTL and testbench



---
 rtl/aoi21_pipe_array.sv | 186 ++++++++++++++++++
 tb/tb_aoi21_pipe_array.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aoi21_pipe_array.sv
// -----------------------------------------------------------------------------
// aoi21_pipe_array
//
// Purpose:
//   WIDTH independent AOI21 bit-channels (QN = ~((IN1 & IN2) | IN3)) feeding a
//   DEPTH-stage valid/ready register pipeline. Used as a characterisable
//   switching load in the power-test datapath; an optional hardware counter
//   accumulates the number of QN bit toggles seen at the output handshake.
//
// Configuration macro:
//   AOI21_TOGGLE_CNT_EN  defined     -> toggle counter, LAST_QN and CNT_SAT built
//                        not defined -> TOGGLE_CNT = 0, CNT_SAT = 0, CNT_CLR ignored
//
// Parameters:
//   WIDTH  number of AOI21 bit-channels (>= 1)
//   DEPTH  pipeline register stages (>= 1)
//   CNT_W  toggle counter width (>= 4)
//
// Ports:
//   CLK         in   clock, all state on rising edge
//   RSTB        in   synchronous active-low reset
//   IN_VALID    in   upstream data valid
//   IN_READY    out  block accepts input this cycle
//   IN1/2/3     in   [WIDTH] per-channel operands
//   OUT_VALID   out  QN valid
//   OUT_READY   in   downstream accepts QN
//   QN          out  [WIDTH] registered AOI21 result
//   CNT_CLR     in   synchronous toggle counter clear
//   TOGGLE_CNT  out  [CNT_W] accumulated QN bit toggles
//   CNT_SAT     out  toggle counter saturated (sticky)
//
// Handshake: a transfer happens on a rising CLK edge where VALID and READY are
// both 1. Once VALID is raised, the producer holds VALID and data stable until
// that transfer; READY may depend combinationally on the consumer side.
// -----------------------------------------------------------------------------
module aoi21_pipe_array #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN1,
   input  logic [WIDTH-1:0] IN2,
   input  logic [WIDTH-1:0] IN3,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] QN,
   input  logic             CNT_CLR,
   output logic [CNT_W-1:0] TOGGLE_CNT,
   output logic             CNT_SAT
);

   // ---------------------------------------------------------------------------
   // Pipeline stages
   // ---------------------------------------------------------------------------
   logic [DEPTH-1:0] v_q, v_d;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] adv;     // stage k hands its word downstream this cycle
   logic [DEPTH-1:0] load;    // stage k may take a new word this cycle
   logic [WIDTH-1:0] aoi_w;
   logic             in_hs;

   assign aoi_w = ~((IN1 & IN2) | IN3);

   // Advance ripples back from the output: a stage can move on when the slot
   // after it is empty or itself moving. The last stage only needs OUT_READY.
   always_comb begin
      adv             = '0;
      adv[DEPTH-1]    = OUT_READY;
      for (int k = DEPTH - 2; k >= 0; k--) begin
         adv[k] = !v_q[k+1] | adv[k+1];
      end
      load = ~v_q | adv;
   end

   // Reset gating keeps the upstream from seeing a ready slot while the
   // pipeline is being cleared.
   assign IN_READY = RSTB & load[0];
   assign in_hs    = IN_VALID & IN_READY;

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      if (load[0]) begin
         v_d[0] = in_hs;
         if (in_hs) begin
            data_d[0] = aoi_w;
         end
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (load[k]) begin
            v_d[k] = v_q[k-1];
            // Data registers only change when a real word moves in, which
            // keeps QN stable while the stage sits empty or stalled.
            if (v_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
      end
   end

   assign OUT_VALID = v_q[DEPTH-1];
   assign QN        = data_q[DEPTH-1];

   // ---------------------------------------------------------------------------
   // Output toggle counter
   // ---------------------------------------------------------------------------
`ifdef AOI21_TOGGLE_CNT_EN
   logic [WIDTH-1:0] last_qn_q, last_qn_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   logic [WIDTH-1:0] diff_w;
   logic [CNT_W:0]   pop_w;
   logic [CNT_W:0]   sum_w;
   logic             out_hs;

   assign out_hs = v_q[DEPTH-1] & OUT_READY;
   assign diff_w = QN ^ last_qn_q;

   always_comb begin
      pop_w = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_w = pop_w + {{CNT_W{1'b0}}, diff_w[i]};
      end
      // One extra bit so an overflowing add is visible and can be clamped.
      sum_w = {1'b0, cnt_q} + pop_w;

      cnt_d     = cnt_q;
      sat_d     = sat_q;
      last_qn_d = last_qn_q;
      if (out_hs) begin
         last_qn_d = QN;
      end
      // Clear has priority over counting; LAST_QN still tracks the transfer.
      if (CNT_CLR) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (out_hs) begin
         if (sum_w[CNT_W]) begin
            cnt_d = '1;
            sat_d = 1'b1;
         end else begin
            cnt_d = sum_w[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         last_qn_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         sat_q     <= sat_d;
         last_qn_q <= last_qn_d;
      end
   end

   assign TOGGLE_CNT = cnt_q;
   assign CNT_SAT    = sat_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = CNT_CLR;
   assign TOGGLE_CNT     = '0;
   assign CNT_SAT        = 1'b0;
`endif

endmodule

// File: tb/tb_aoi21_pipe_array.sv
module tb_aoi21_pipe_array;

   localparam int W  = 8;
   localparam int D  = 2;
   localparam int CW = 4;

   logic          CLK;
   logic          RSTB;
   logic          IN_VALID;
   logic          IN_READY;
   logic [W-1:0]  IN1, IN2, IN3;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [W-1:0]  QN;
   logic          CNT_CLR;
   logic [CW-1:0] TOGGLE_CNT;
   logic          CNT_SAT;

   int checks   = 0;
   int failures = 0;
   int last_wait;
   int stall_sum;

   logic [W-1:0] exp_q[$];
   logic         mon_en    = 1'b0;
   logic         held_v    = 1'b0;
   logic [W-1:0] held_qn   = '0;

   typedef struct {
      logic [W-1:0] in1;
      logic [W-1:0] in2;
      logic [W-1:0] in3;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[8];

   aoi21_pipe_array #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      .CLK        (CLK),
      .RSTB       (RSTB),
      .IN_VALID   (IN_VALID),
      .IN_READY   (IN_READY),
      .IN1        (IN1),
      .IN2        (IN2),
      .IN3        (IN3),
      .OUT_VALID  (OUT_VALID),
      .OUT_READY  (OUT_READY),
      .QN         (QN),
      .CNT_CLR    (CNT_CLR),
      .TOGGLE_CNT (TOGGLE_CNT),
      .CNT_SAT    (CNT_SAT)
   );

   // ---------------- clock ----------------
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] aoi_model(input logic [W-1:0] a, b, c);
      return ~((a & b) | c);
   endfunction

   function automatic logic [CW-1:0] exp_cnt(input logic [CW-1:0] v);
`ifdef AOI21_TOGGLE_CNT_EN
      return v;
`else
      return '0;
`endif
   endfunction

   function automatic logic exp_sat(input logic s);
`ifdef AOI21_TOGGLE_CNT_EN
      return s;
`else
      return 1'b0;
`endif
   endfunction

   // ---------------- driver ----------------
   // Presents one word and waits for its handshake; returns at posedge+1.
   // IN_VALID is left high so back-to-back calls stream without bubbles.
   task automatic send(input logic [W-1:0] a, b, c, e);
      int n;
      bit done;
      n    = 0;
      done = 0;
      IN1 = a; IN2 = b; IN3 = c;
      IN_VALID = 1'b1;
      while (!done) begin
         @(negedge CLK);
         if (IN_READY) begin
            done = 1;
         end else begin
            n++;
            if (n > 300) begin
               check("in_ready_timeout", 32'd0, 32'd1);
               IN_VALID = 1'b0;
               last_wait = n;
               return;
            end
         end
      end
      @(posedge CLK);
      exp_q.push_back(e);
      #1;
      last_wait = n;
   endtask

   // Wait until every expected word has left; returns at posedge+1 of the
   // last output handshake.
   task automatic wait_out();
      int n;
      n = 0;
      while (exp_q.size() != 0) begin
         @(posedge CLK);
         n++;
         if (n > 300) begin
            check("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
         end
      end
      #1;
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge CLK) begin
      if (mon_en) begin
         if (held_v) begin
            check("stall_valid_hold", {31'd0, OUT_VALID}, 32'd1);
            check("stall_qn_hold", {24'd0, QN}, {24'd0, held_qn});
         end
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", {24'd0, QN}, 32'hFFFF_FFFF);
            end else begin
               check("qn_data", {24'd0, QN}, {24'd0, exp_q.pop_front()});
            end
         end
         held_v  = OUT_VALID & ~OUT_READY;
         held_qn = QN;
      end else begin
         held_v = 1'b0;
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{8'hF0, 8'hCC, 8'h0A, 8'h35};
      vecs[1] = '{8'h00, 8'h00, 8'h00, 8'hFF};
      vecs[2] = '{8'hFF, 8'hFF, 8'h00, 8'h00};
      vecs[3] = '{8'hFF, 8'h0F, 8'hF0, 8'h00};
      vecs[4] = '{8'hAA, 8'h55, 8'h00, 8'hFF};
      vecs[5] = '{8'h3C, 8'hFF, 8'h00, 8'hC3};
      vecs[6] = '{8'h12, 8'h34, 8'h40, 8'hAF};
      vecs[7] = '{8'h00, 8'h00, 8'h0F, 8'hF0};

      // Reset with IN_VALID asserted
      RSTB = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1; CNT_CLR = 1'b0;
      IN1 = 8'hFF; IN2 = 8'hFF; IN3 = 8'h00;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_qn", {24'd0, QN}, 32'd0);
      check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
      check("rst_in_ready", {31'd0, IN_READY}, 32'd0);
      check("rst_toggle_cnt", {28'd0, TOGGLE_CNT}, 32'd0);
      check("rst_cnt_sat", {31'd0, CNT_SAT}, 32'd0);
      @(posedge CLK); #1;
      RSTB = 1'b1; IN_VALID = 1'b0; mon_en = 1'b1;
      @(negedge CLK);
      check("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);
      @(posedge CLK); #1;

      // Truth table vector and latency
      send(8'hF0, 8'hCC, 8'h0A, 8'h35);
      IN_VALID = 1'b0;
      @(negedge CLK);
      check("latency_cycle1_valid", {31'd0, OUT_VALID}, 32'd0);
      @(negedge CLK);
      check("latency_cycle2_valid", {31'd0, OUT_VALID}, 32'd1);
      check("latency_cycle2_qn", {24'd0, QN}, 32'h35);
      wait_out();

      // Table vectors streamed back-to-back: every word accepted without stall
      stall_sum = 0;
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].in1, vecs[i].in2, vecs[i].in3, vecs[i].exp);
         stall_sum += last_wait;
      end
      IN_VALID = 1'b0;
      check("stream_no_stall", stall_sum, 32'd0);
      wait_out();

      // Backpressure: 6 words, OUT_READY low for 5 edges starting at cycle 3
      fork
         begin
            for (int w = 1; w <= 6; w++) begin
               send(8'h00, 8'h00, w[7:0], ~w[7:0]);
            end
            IN_VALID = 1'b0;
         end
         begin
            repeat (3) @(posedge CLK);
            #1 OUT_READY = 1'b0;
            repeat (2) @(posedge CLK);
            @(negedge CLK);
            check("full_in_ready", {31'd0, IN_READY}, 32'd0);
            check("full_out_valid", {31'd0, OUT_VALID}, 32'd1);
            repeat (3) @(posedge CLK);
            #1 OUT_READY = 1'b1;
         end
      join
      wait_out();

      // Random stream against random backpressure
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               logic [W-1:0] a, b, c;
               a = W'($urandom_range(0, 255));
               b = W'($urandom_range(0, 255));
               c = W'($urandom_range(0, 255));
               send(a, b, c, aoi_model(a, b, c));
               if ($urandom_range(0, 3) == 0) begin
                  IN_VALID = 1'b0;
                  @(posedge CLK); #1;
               end
            end
            IN_VALID = 1'b0;
         end
         begin
            for (int i = 0; i < 60; i++) begin
               @(posedge CLK);
               #1 OUT_READY = 1'($urandom_range(0, 1));
            end
            OUT_READY = 1'b1;
         end
      join
      wait_out();

      // Mid-stream reset discards in-flight data
      OUT_READY = 1'b0;
      send(8'h11, 8'h11, 8'h00, 8'hEE);
      IN_VALID = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("pre_rst_valid", {31'd0, OUT_VALID}, 32'd1);
      mon_en = 1'b0;
      @(posedge CLK); #1;
      RSTB = 1'b0;
      @(posedge CLK); #1;
      RSTB = 1'b1; OUT_READY = 1'b1;
      exp_q.delete();
      mon_en = 1'b1;
      @(negedge CLK);
      check("mid_rst_valid", {31'd0, OUT_VALID}, 32'd0);
      check("mid_rst_qn", {24'd0, QN}, 32'd0);
      @(posedge CLK); #1;

      // Toggle count: outputs 00, FF, 0F
      send(8'h00, 8'h00, 8'hFF, 8'h00); IN_VALID = 1'b0; wait_out();
      check("tog_00", {28'd0, TOGGLE_CNT}, {28'd0, exp_cnt(4'd0)});
      send(8'h00, 8'h00, 8'h00, 8'hFF); IN_VALID = 1'b0; wait_out();
      check("tog_ff", {28'd0, TOGGLE_CNT}, {28'd0, exp_cnt(4'd8)});
      send(8'h00, 8'h00, 8'hF0, 8'h0F); IN_VALID = 1'b0; wait_out();
      check("tog_0f", {28'd0, TOGGLE_CNT}, {28'd0, exp_cnt(4'd12)});
      check("tog_sat_low", {31'd0, CNT_SAT}, 32'd0);

      // Saturation: 12 + 4 overflows the 4-bit counter, then it sticks
      send(8'h00, 8'h00, 8'hFF, 8'h00); IN_VALID = 1'b0; wait_out();
      check("sat_cnt_1", {28'd0, TOGGLE_CNT}, {28'd0, exp_cnt(4'd15)});
      check("sat_flag_1", {31'd0, CNT_SAT}, {31'd0, exp_sat(1'b1)});
      send(8'h00, 8'h00, 8'h00, 8'hFF); IN_VALID = 1'b0; wait_out();
      check("sat_cnt_2", {28'd0, TOGGLE_CNT}, {28'd0, exp_cnt(4'd15)});
      check("sat_flag_2", {31'd0, CNT_SAT}, {31'd0, exp_sat(1'b1)});
      send(8'h00, 8'h00, 8'hFF, 8'h00); IN_VALID = 1'b0; wait_out();
      check("sat_cnt_3", {28'd0, TOGGLE_CNT}, {28'd0, exp_cnt(4'd15)});

      // Clear coincident with a transfer of FF (LAST_QN = 00 before it)
      OUT_READY = 1'b0;
      send(8'h00, 8'h00, 8'h00, 8'hFF);
      IN_VALID = 1'b0;
      begin
         int n;
         n = 0;
         while (!OUT_VALID && n < 50) begin
            @(posedge CLK); #1;
            n++;
         end
         check("clr_setup_valid", {31'd0, OUT_VALID}, 32'd1);
      end
      CNT_CLR = 1'b1; OUT_READY = 1'b1;
      @(posedge CLK); #1;
      CNT_CLR = 1'b0;
      check("clr_cnt", {28'd0, TOGGLE_CNT}, 32'd0);
      check("clr_sat", {31'd0, CNT_SAT}, 32'd0);
      wait_out();
      // Next transfer counts from LAST_QN = FF
      send(8'h00, 8'h00, 8'hF0, 8'h0F); IN_VALID = 1'b0; wait_out();
      check("post_clr_cnt", {28'd0, TOGGLE_CNT}, {28'd0, exp_cnt(4'd4)});
      check("post_clr_sat", {31'd0, CNT_SAT}, 32'd0);

      repeat (3) @(posedge CLK);
      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
